dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the core load/store path (port 0) and a debug/DMA loader (port 1).
- Each cycle it picks at most one request, drives the memory, and returns read data to the requester that issued it.
- Read data returns after a fixed memory latency.
- Sits between the core datapath / debug loader and the data memory. It raises core_stall so the core holds its PC while its access is not granted.

---
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin with a bounded burst lock for port 1.
// Optional macro ARB_PERF_CNT_EN adds a saturating contention counter on perf_conflicts.
module dmem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          core_stall,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [31:0]   perf_conflicts
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    port_e            last_q, last_d;
    logic             m1_gnt_q;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [RD_LAT-1:0] tag_vld_q;
    logic [RD_LAT-1:0] tag_port_q;
    logic             lock_hit;
    logic             rd_issue;
    logic             ret_vld;

    // Lock only extends a grant port 1 actually held in the previous cycle.
    assign lock_hit = m1_gnt_q & m1_lock & m1_req & (hold_cnt_q < HOLD_MAX);

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                if (lock_hit) begin
                    m1_gnt = 1'b1;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    m0_gnt = 1'b1;
                end else if (last_q == PORT1) begin
                    m0_gnt = 1'b1;
                end else begin
                    m1_gnt = 1'b1;
                end
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        if (m0_gnt) begin
            last_d = PORT0;
        end else if (m1_gnt) begin
            last_d = PORT1;
        end
        if (m0_gnt || !m1_lock) begin
            hold_cnt_d = '0;
        end else if (m1_gnt && lock_hit && m0_req) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_comb begin
        mem_en    = m0_gnt | m1_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    assign rd_issue   = mem_en & ~mem_we;
    assign core_stall = m0_req & ~m0_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= PORT0;
            m1_gnt_q   <= 1'b0;
            hold_cnt_q <= '0;
            tag_vld_q  <= '0;
            tag_port_q <= '0;
        end else begin
            last_q        <= last_d;
            m1_gnt_q      <= m1_gnt;
            hold_cnt_q    <= hold_cnt_d;
            tag_vld_q[0]  <= rd_issue;
            tag_port_q[0] <= m1_gnt;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_port_q[i] <= tag_port_q[i-1];
            end
        end
    end

    // Return path is masked while reset is held so flushed reads never surface.
    assign ret_vld   = tag_vld_q[RD_LAT-1] & ~rst;
    assign m0_rvalid = ret_vld & ~tag_port_q[RD_LAT-1];
    assign m1_rvalid = ret_vld &  tag_port_q[RD_LAT-1];
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (m0_req && m1_req && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_conflicts = perf_q;
`else
    assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (RD_LAT 1..3) share stimulus;
// a per-cycle scoreboard of expected issues predicts grants, mem strobes and returns.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        m0_gnt_w[3], m0_rvalid_w[3], core_stall_w[3];
    logic        m1_gnt_w[3], m1_rvalid_w[3], mem_en_w[3], mem_we_w[3];
    logic [31:0] m0_rdata_w[3], m1_rdata_w[3], mem_addr_w[3], mem_wdata_w[3];
    logic [31:0] mem_rdata_w[3], perf_w[3];
    logic [31:0] ap[3];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        dmem_arbiter #(
            .AW(32), .DW(32), .RD_LAT(k + 1), .MAX_HOLD(8)
        ) u_dut (
            .clk(clk), .rst(rst),
            .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
            .m0_gnt(m0_gnt_w[k]), .m0_rvalid(m0_rvalid_w[k]), .m0_rdata(m0_rdata_w[k]),
            .core_stall(core_stall_w[k]),
            .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
            .m1_lock(m1_lock),
            .m1_gnt(m1_gnt_w[k]), .m1_rvalid(m1_rvalid_w[k]), .m1_rdata(m1_rdata_w[k]),
            .mem_en(mem_en_w[k]), .mem_we(mem_we_w[k]), .mem_addr(mem_addr_w[k]),
            .mem_wdata(mem_wdata_w[k]), .mem_rdata(mem_rdata_w[k]),
            .perf_conflicts(perf_w[k])
        );
        assign mem_rdata_w[k] = mem_fn(ap[k]);
    end

    // Memory model: read data for the address issued k+1 cycles ago.
    always @(posedge clk) begin
        ap[0] <= mem_addr_w[0];
        ap[1] <= ap[0];
        ap[2] <= ap[1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    logic        hv[256];
    logic        hp[256];
    logic [31:0] ha[256];
    int          cyc      = 0;
    int          last_rst = -1;
    logic [31:0] perf_exp = '0;

    // One cycle: inputs already driven after the rising edge; check at the falling edge.
    task automatic step(input int eg);
        int          idx;
        logic        ev0, ev1, ew;
        logic [31:0] ea, ed;
        @(negedge clk);
        if (rst) last_rst = cyc;
        ea = (eg == 0) ? m0_addr  : (eg == 1) ? m1_addr  : 32'h0;
        ed = (eg == 0) ? m0_wdata : (eg == 1) ? m1_wdata : 32'h0;
        ew = (eg == 0) ? m0_we    : (eg == 1) ? m1_we    : 1'b0;
        check($sformatf("c%0d m0_gnt", cyc), 32'(m0_gnt_w[0]), 32'(eg == 0));
        check($sformatf("c%0d m1_gnt", cyc), 32'(m1_gnt_w[0]), 32'(eg == 1));
        check($sformatf("c%0d mem_en", cyc), 32'(mem_en_w[0]), 32'(eg >= 0));
        check($sformatf("c%0d mem_we", cyc), 32'(mem_we_w[0]), 32'(ew));
        check($sformatf("c%0d mem_addr", cyc), mem_addr_w[0], ea);
        check($sformatf("c%0d mem_wdata", cyc), mem_wdata_w[0], ed);
        check($sformatf("c%0d core_stall", cyc), 32'(core_stall_w[0]), 32'(m0_req && eg != 0));
        for (int k = 0; k < 3; k++) begin
            idx = cyc - (k + 1);
            ev0 = 1'b0;
            ev1 = 1'b0;
            if (idx >= 0 && idx > last_rst && hv[idx]) begin
                ev0 = !hp[idx];
                ev1 = hp[idx];
            end
            check($sformatf("c%0d L%0d m0_rvalid", cyc, k + 1), 32'(m0_rvalid_w[k]), 32'(ev0));
            check($sformatf("c%0d L%0d m1_rvalid", cyc, k + 1), 32'(m1_rvalid_w[k]), 32'(ev1));
            check($sformatf("c%0d L%0d m0_rdata", cyc, k + 1), m0_rdata_w[k],
                  ev0 ? mem_fn(ha[idx]) : 32'h0);
            check($sformatf("c%0d L%0d m1_rdata", cyc, k + 1), m1_rdata_w[k],
                  ev1 ? mem_fn(ha[idx]) : 32'h0);
        end
`ifdef ARB_PERF_CNT_EN
        check($sformatf("c%0d perf", cyc), perf_w[0], perf_exp);
`else
        check($sformatf("c%0d perf", cyc), perf_w[0], 32'h0);
`endif
        hv[cyc] = (eg >= 0) && !ew;
        hp[cyc] = (eg == 1);
        ha[cyc] = ea;
        if (rst) perf_exp = '0;
        else if (m0_req && m1_req && perf_exp != 32'hFFFF_FFFF) perf_exp = perf_exp + 1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(-1);
        step(-1);
        rst = 1'b0;

        // Single read from port 0.
        m0_req = 1'b1; m0_addr = 32'h10;
        step(0);
        m0_req = 1'b0;
        repeat (3) step(-1);

        // Lone port-1 write leaves port 1 as last served.
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1234;
        step(1);

        // Contention, no lock: strict alternation starting at port 0.
        m1_we = 1'b0; m0_req = 1'b1; m0_addr = 32'h100; m1_addr = 32'h200;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                step(0);
                m0_addr = m0_addr + 32'd4;
            end else begin
                step(1);
                m1_addr = m1_addr + 32'd4;
            end
        end

        // Locked burst of port-1 writes; port 0 waits exactly MAX_HOLD re-grants.
        m0_req = 1'b0; m1_lock = 1'b1; m1_we = 1'b1; m1_addr = 32'h400; m1_wdata = 32'h5000;
        step(1);
        m0_req = 1'b1; m0_addr = 32'h300;
        for (int i = 0; i < 8; i++) begin
            m1_addr  = m1_addr + 32'd4;
            m1_wdata = m1_wdata + 32'd1;
            step(1);
        end
        step(0);
        m0_req = 1'b0; m1_addr = m1_addr + 32'd4;
        step(1);
        m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0;
        repeat (3) step(-1);

        // Consecutive reads from different ports.
        m0_req = 1'b1; m0_addr = 32'h40;
        step(0);
        m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h80;
        step(1);
        m1_req = 1'b0;
        repeat (4) step(-1);

        // Reset one cycle after a read grant.
        m0_req = 1'b1; m0_addr = 32'h55;
        step(0);
        m0_req = 1'b0; rst = 1'b1;
        step(-1);
        rst = 1'b0;
        repeat (4) step(-1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
